// File: rtl/shift_exec_pipe.sv
// Two-stage pipelined shift unit: SLL/SRL/SRA/ROR with a tag.
// S1 latches operands; S2 latches the shifted result.
module shift_exec_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_n,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [31:0]      x;
    logic [4:0]       s;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      res_q, res_d;
  logic             zero_q, zero_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic        s2_free;
  logic        s1_adv;
  logic        accept;
  logic [31:0] calc;
  logic [63:0] rot;

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !rst && !flush && (!s1_valid_q || s1_adv);
  assign accept   = in_valid && in_ready;

  // Rotate via a doubled word so s=0 naturally yields x.
  always_comb begin
    calc = s1_q.x;
    rot  = {s1_q.x, s1_q.x} >> s1_q.s;
    unique case (1'b1)
      (s1_q.op == OP_SLL): begin
        calc = s1_q.sat ? 32'h0 : (s1_q.x << s1_q.s);
      end
      (s1_q.op == OP_SRL): begin
        calc = s1_q.sat ? 32'h0 : (s1_q.x >> s1_q.s);
      end
      (s1_q.op == OP_SRA): begin
        if (s1_q.sat)
          calc = {32{s1_q.x[31]}};
        else
          calc = 32'($signed(s1_q.x) >>> s1_q.s);
      end
      (s1_q.op == OP_ROR): begin
        calc = rot[31:0];
      end
      default: calc = s1_q.x;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (flush)
      s1_valid_d = 1'b0;
    else if (accept) begin
      s1_valid_d = 1'b1;
      s1_d.op    = op_e'(in_op);
      s1_d.x     = in_x;
      s1_d.s     = in_n[4:0];
      s1_d.sat   = (in_n[31:5] != 27'h0);
      s1_d.tag   = in_tag;
    end else if (s1_adv)
      s1_valid_d = 1'b0;
  end

  // Result and tag hold their last value once consumed.
  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    zero_d     = zero_q;
    tag_d      = tag_q;
    if (flush)
      s2_valid_d = 1'b0;
    else if (s1_adv) begin
      s2_valid_d = 1'b1;
      res_d      = calc;
      zero_d     = (calc == 32'h0);
      tag_d      = s1_q.tag;
    end else if (out_ready)
      s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= 32'h0;
      zero_q     <= 1'b1;
      tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      tag_q      <= tag_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_tag    = tag_q;

endmodule
